// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock parametrised FIFO family.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W_DEF = 32'd8;
    localparam int unsigned FIFO_DEPTH_DEF  = 32'd16;

    localparam int unsigned FIFO_MODE_REG  = 32'd0;
    localparam int unsigned FIFO_MODE_FWFT = 32'd1;

    // Ceiling log2, usable in parameter and port-range expressions.
    function automatic int unsigned fifo_clog2(input int unsigned value);
        int unsigned result;
        result = 32'd0;
        while ((64'd1 << result) < 64'(value)) begin
            result = result + 32'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module fifo_mem_dp
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W_DEF,
    parameter int unsigned DEPTH  = FIFO_DEPTH_DEF,
    parameter int unsigned ADDR_W = fifo_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Storage is deliberately left unreset; contents are qualified by the FIFO count.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_buffer_sync_param.sv
// Single-clock elastic FIFO with occupancy count, programmable thresholds,
// sticky error flags and selectable registered / first-word-fall-through read.
module fifo_buffer_sync_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = FIFO_DATA_W_DEF,
    parameter int unsigned DEPTH     = FIFO_DEPTH_DEF,
    parameter int unsigned AF_THRESH = DEPTH - 32'd2,
    parameter int unsigned AE_THRESH = 32'd2,
    parameter int unsigned FWFT      = FIFO_MODE_REG
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic [DATA_W-1:0]                  wr_data,
    input  logic                               rd_en,
    output logic [DATA_W-1:0]                  rd_data,
    output logic                               rd_valid,
    output logic                               empty,
    output logic                               full,
    output logic                               almost_empty,
    output logic                               almost_full,
    output logic [fifo_clog2(DEPTH+32'd1)-1:0] count,
    output logic                               overflow,
    output logic                               underflow,
    input  logic                               clr_err
);

    localparam int unsigned CNT_W = fifo_clog2(DEPTH + 32'd1);
    localparam int unsigned PTR_W = fifo_clog2(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

    if ((DEPTH < 32'd2) || ((DEPTH & (DEPTH - 32'd1)) != 32'd0)) begin : g_bad_depth
        $error("fifo_buffer_sync_param: DEPTH must be a power of two >= 2");
    end
    if (DATA_W < 32'd1) begin : g_bad_width
        $error("fifo_buffer_sync_param: DATA_W must be >= 1");
    end
    if ((AF_THRESH < 32'd1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("fifo_buffer_sync_param: AF_THRESH must lie in 1..DEPTH");
    end
    if (AE_THRESH > (DEPTH - 32'd1)) begin : g_bad_ae
        $error("fifo_buffer_sync_param: AE_THRESH must lie in 0..DEPTH-1");
    end
    if (FWFT > FIFO_MODE_FWFT) begin : g_bad_mode
        $error("fifo_buffer_sync_param: FWFT must be 0 or 1");
    end

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              almost_empty_q, almost_empty_d;
    logic              almost_full_q, almost_full_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic [DATA_W-1:0] mem_rdata_s;

    fifo_mem_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata_s)
    );

    // Accept decisions, pointer/count next state and flags derived from the next count.
    always_comb begin
        wr_acc_s = wr_en & ~full_q;
        rd_acc_s = rd_en & ~empty_q;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        empty_d        = (count_d == CNT_W'(0));
        full_d         = (count_d == DEPTH_C);
        almost_empty_d = (count_d <= AE_C);
        almost_full_d  = (count_d >= AF_C);

        // A fresh error in the clearing cycle keeps the flag set.
        overflow_d  = (wr_en & full_q)  | (overflow_q  & ~clr_err);
        underflow_d = (rd_en & empty_q) | (underflow_q & ~clr_err);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_empty_q <= almost_empty_d;
            almost_full_q  <= almost_full_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is presented directly; forced to zero while nothing is stored.
        assign rd_data  = empty_q ? '0 : mem_rdata_s;
        assign rd_valid = ~empty_q;
    end else begin : g_reg_read
        logic [DATA_W-1:0] rd_data_q, rd_data_d;
        logic              rd_valid_q;

        // Output register loads only on an accepted read, otherwise holds.
        always_comb begin
            if (rd_acc_s) begin
                rd_data_d = mem_rdata_s;
            end else begin
                rd_data_d = rd_data_q;
            end
        end

        // Registered read data with a one-cycle valid strobe.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_acc_s;
            end
        end

        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = almost_empty_q;
    assign almost_full  = almost_full_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: doc/fifo_buffer_sync_param.md
Name: fifo_buffer_sync_param

Overview:
Single-clock, parametrised successor to the team's 8-bit/4-deep FIFO buffer, generalised in data width and depth. Adds:
- occupancy count
- programmable almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- selectable read mode: registered read or first-word-fall-through (FWFT)

Used as the standard elastic buffer between producer/consumer stages sharing one clock domain.

Parameters:
- DATA_W, 8, data word width in bits (>=1)
- DEPTH, 16, number of entries; power of two, >=2
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
- FWFT, 0, 0 = registered read, 1 = first-word-fall-through

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request (FWFT=1: pop/acknowledge of head word)
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data is valid
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AE_THRESH
- almost_full  out  1  count >= AF_THRESH
- count  out  CNT_W  occupancy, CNT_W = clog2(DEPTH+1)
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (rst_n low, async assert, sync release to clk):
  - wr_ptr = rd_ptr = 0, count = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0
  - rd_data = 0, rd_valid = 0, overflow = underflow = 0
  - Storage array is not reset.
  - Reset mid-operation discards all contents immediately.
- Accept rules, evaluated per cycle on registered flags:
  - wr_acc = wr_en & !full
  - rd_acc = rd_en & !empty
- Write: on wr_acc, mem[wr_ptr] <= wr_data; wr_ptr increments, wrapping DEPTH-1 -> 0 (ptr width clog2(DEPTH)).
- Read, FWFT=0:
  - on rd_acc, rd_data <= mem[rd_ptr] and rd_ptr increments with wrap
  - rd_valid = 1 in the following cycle only (one-cycle latency)
  - rd_data holds its last value when no read is accepted
- Read, FWFT=1:
  - rd_data = mem[rd_ptr] combinationally; rd_valid = !empty
  - rd_acc advances rd_ptr
  - a word written into an empty FIFO appears on rd_data the cycle after the write (zero added latency beyond storage)
- count update:
  - +1 on wr_acc & !rd_acc
  - -1 on rd_acc & !wr_acc
  - unchanged on both or neither
- All flags are registered and derived from the next count value, so they are valid in the same cycle as count.
- Simultaneous rd_en & wr_en:
  - when neither empty nor full: both accepted, count unchanged
  - when full: only the read is accepted; the write is rejected and sets overflow
  - when empty: only the write is accepted; the read is rejected and sets underflow
  - No bypass path.
- Error flags:
  - overflow <= 1 on wr_en & full; underflow <= 1 on rd_en & empty
  - clr_err clears both; a new error in the same cycle as clr_err wins (flag stays 1)
  - Rejected requests never change pointers, count or memory.
- Wrap-around: pointer wrap is transparent; full and empty are distinguished solely by count.
- Threshold parameters outside their legal ranges: elaboration-time error via a generate-time check.

Decomposition:
- Shared package/header fifo_pkg:
  - clog2 constant function
  - default DATA_W/DEPTH constants
  - read-mode constants FIFO_MODE_REG = 0, FIFO_MODE_FWFT = 1
- One sub-module, fifo_mem_dp:
  - DEPTH x DATA_W array
  - one synchronous write port, one asynchronous read port
- Top module holds pointers, count, flags, read-register logic and error logic.

Test Plan:
- Reset then idle (DATA_W=8, DEPTH=16, FWFT=0) -> empty=1, almost_empty=1, count=0, full=0, rd_valid=0, overflow=underflow=0.
- Write 0x01..0x10 (16 words) -> count steps to 16; almost_full rises at count 14; full=1 after the 16th write. A 17th write (0xAA) -> overflow=1, count stays 16. Then read 16 -> rd_data 0x01..0x10 in order, each 1 cycle after rd_en; empty=1 at the end.
- Fill to 8, then hold wr_en=rd_en=1 for 40 cycles with an incrementing pattern -> count stays 8, pointers wrap at least twice, output order is preserved with no loss.
- Full FIFO with wr_en=rd_en=1 for one cycle -> only the read is accepted: count 16 -> 15, overflow=1. Empty FIFO with wr_en=rd_en=1 -> only the write is accepted: count 0 -> 1, underflow=1. clr_err asserted alone -> both flags 0 next cycle; clr_err with a concurrent rd_en on empty -> underflow remains 1.
- FWFT=1: write 0x5A into empty -> next cycle rd_valid=1, rd_data=0x5A without rd_en. rd_en pops it -> rd_valid=0, empty=1.
- Write 5 words, assert rst_n=0 mid-cycle (asynchronously) -> outputs return to reset values immediately, count=0. After release, the first read shows only newly written data.
